// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads to the I-cache and
// presents a registered {valid, pc, instruction} packet to decode.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] imm;
    } rv32i_data_t;

    typedef struct packed {
        logic        valid;
        rv32i_data_t data;
    } rv32i_packet_t;

endpackage

module if_fetch
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          correct_pc_prediction,
    input  logic [31:0]   redirect_pc,
    output logic          inst_mem_read,
    output logic [31:0]   inst_mem_address,
    input  logic [31:0]   inst_mem_rdata,
    input  logic          inst_mem_resp,
    output rv32i_packet_t if_out
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   drop_addr;
    rv32i_packet_t out_q;
    logic          buf_valid;
    logic [31:0]   buf_pc;
    logic [31:0]   buf_inst;
    logic [31:0]   pc_inc;

    function automatic rv32i_packet_t make_pkt(input logic        vld,
                                               input logic [31:0] pc_i,
                                               input logic [31:0] inst_i);
        rv32i_packet_t p;
        p                  = '0;
        p.valid            = vld;
        p.data.pc          = pc_i;
        p.data.instruction = inst_i;
        return p;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign pc_inc = pc + 32'd4;

    // The cache cannot abort, so a dropped request keeps its original address
    // on the bus while pc already holds the redirect target.
    assign inst_mem_read    = !rst && (state != HOLD);
    assign inst_mem_address = (state == DROP) ? drop_addr : pc;
    assign if_out           = out_q;

    // ---- IF/ID register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            out_q     <= '0;
            buf_valid <= 1'b0;
        end else if (!correct_pc_prediction) begin
            out_q.valid <= 1'b0;
            buf_valid   <= 1'b0;
            pc          <= align_word(redirect_pc);
            case (state)
                FETCH: begin
                    if (!inst_mem_resp) begin
                        state     <= DROP;
                        drop_addr <= pc;
                    end
                end
                HOLD:    state <= FETCH;
                DROP:    if (inst_mem_resp) state <= FETCH;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (inst_mem_resp) begin
                        pc <= pc_inc;
                        if (stall && out_q.valid) begin
                            buf_valid <= 1'b1;
                            buf_pc    <= pc;
                            buf_inst  <= inst_mem_rdata;
                            state     <= HOLD;
                        end else begin
                            out_q <= make_pkt(1'b1, pc, inst_mem_rdata);
                        end
                    end else if (!stall) begin
                        out_q.valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        out_q     <= make_pkt(buf_valid, buf_pc, buf_inst);
                        buf_valid <= 1'b0;
                        state     <= FETCH;
                    end
                end
                DROP: begin
                    if (inst_mem_resp) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Random-stimulus bench for if_fetch: a behavioural I-cache plus a stream-level
// model of the instruction sequence decode should observe.
module tb_if_fetch;
    import rv32i_types::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0060;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          correct_pc_prediction;
    logic [31:0]   redirect_pc;
    logic          inst_mem_read;
    logic [31:0]   inst_mem_address;
    logic [31:0]   inst_mem_rdata;
    logic          inst_mem_resp;
    rv32i_packet_t if_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall                 (stall),
        .correct_pc_prediction (correct_pc_prediction),
        .redirect_pc           (redirect_pc),
        .inst_mem_read         (inst_mem_read),
        .inst_mem_address      (inst_mem_address),
        .inst_mem_rdata        (inst_mem_rdata),
        .inst_mem_resp         (inst_mem_resp),
        .if_out                (if_out)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic rv32i_packet_t pkt(input logic [31:0] a);
        rv32i_packet_t p;
        p                  = '0;
        p.valid            = 1'b1;
        p.data.pc          = a;
        p.data.instruction = mem_word(a);
        return p;
    endfunction

    // cache model
    bit            c_busy;
    bit            c_stale;
    int            c_cnt;
    logic [31:0]   c_addr;
    // stream model
    logic [31:0]   fetch_ptr;
    logic [31:0]   exp_pc;
    bit            buffered;
    rv32i_packet_t buf_pkt;
    rv32i_packet_t model_out;
    bit            after_rst;
    bit            live;
    int            idle;
    int            rst_left;

    initial begin
        rst                   = 1'b1;
        stall                 = 1'b0;
        correct_pc_prediction = 1'b1;
        redirect_pc           = '0;
        inst_mem_resp         = 1'b0;
        inst_mem_rdata        = '0;
        c_busy                = 0;
        c_stale               = 0;
        c_cnt                 = 0;
        c_addr                = '0;
        fetch_ptr             = RESET_PC;
        exp_pc                = RESET_PC;
        buffered              = 0;
        buf_pkt               = '0;
        model_out             = '0;
        after_rst             = 0;
        idle                  = 0;
        rst_left              = 1;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            rst = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            else if (cyc > 40 && $urandom_range(299) == 0) rst_left = 1 + $urandom_range(2);
            // opening stretch: zero-wait cache, no stalls, no redirects
            stall                 = (cyc >= 30) && ($urandom_range(99) < 30);
            correct_pc_prediction = !((cyc >= 30) && ($urandom_range(99) < 6));
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else                        redirect_pc = $urandom;
            inst_mem_resp  = !rst && c_busy && (c_cnt == 0);
            inst_mem_rdata = inst_mem_resp ? mem_word(c_addr) : $urandom;
            #1;

            if (rst) begin
                check_eq("read_in_reset", 128'(inst_mem_read), 128'(0));
            end else begin
                if (after_rst)
                    check_eq("first_req_after_reset", 128'({inst_mem_read, inst_mem_address}),
                             128'({1'b1, RESET_PC}));
                if (c_busy)
                    check_eq("req_held_outstanding", 128'({inst_mem_read, inst_mem_address}),
                             128'({1'b1, c_addr}));
                if (buffered)
                    check_eq("no_read_while_parked", 128'(inst_mem_read), 128'(0));
                if (if_out.valid)
                    check_eq("stream_order", 128'({if_out.data.pc, if_out.data.instruction}),
                             128'({exp_pc, mem_word(exp_pc)}));
            end
            check_eq("if_out_packet", 128'(if_out), 128'(model_out));

            if (rst) begin
                c_busy    = 0;
                fetch_ptr = RESET_PC;
                exp_pc    = RESET_PC;
                buffered  = 0;
                model_out = '0;
                after_rst = 1;
                idle      = 0;
            end else begin
                after_rst = 0;
                live      = inst_mem_resp && !c_stale;
                if (!correct_pc_prediction) begin
                    model_out.valid = 1'b0;
                    buffered        = 0;
                end else begin
                    if (model_out.valid && !stall) begin
                        exp_pc = exp_pc + 32'd4;
                        idle   = 0;
                    end
                    if (buffered && !stall) begin
                        model_out = buf_pkt;
                        buffered  = 0;
                    end else if (live && (!stall || !model_out.valid)) begin
                        model_out = pkt(c_addr);
                    end else if (live) begin
                        buffered = 1;
                        buf_pkt  = pkt(c_addr);
                    end else if (!stall) begin
                        model_out.valid = 1'b0;
                    end
                end

                if (inst_mem_resp) begin
                    c_busy = 0;
                end else if (c_busy) begin
                    c_cnt--;
                end else if (inst_mem_read) begin
                    check_eq("req_addr", 128'(inst_mem_address), 128'(fetch_ptr));
                    c_busy    = 1;
                    c_stale   = 0;
                    c_addr    = inst_mem_address;
                    c_cnt     = (cyc < 30) ? 0 : int'($urandom_range(2));
                    fetch_ptr = fetch_ptr + 32'd4;
                end

                if (!correct_pc_prediction) begin
                    if (c_busy) c_stale = 1;
                    fetch_ptr = {redirect_pc[31:2], 2'b00};
                    exp_pc    = fetch_ptr;
                end

                idle++;
                if (idle == 400) begin
                    check_eq("progress_idle_cycles", 128'(idle), 128'(0));
                    idle = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
